// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC geometry defaults and the PC sequencer state encoding.
package cpu_pkg;

  localparam int PC_WIDTH = 16;
  localparam int PC_STEP  = 2;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH,
    HALTED
  } pc_state_t;

endpackage

// File: rtl/flush_timer.sv
// Four-bit load/decrement counter that times the wrong-path squash window.
// done is high while the count sits at 1, i.e. during the last flush cycle.
module flush_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       dec,
  output logic       done
);

  logic [3:0] count;

  // Load has priority so a fresh jump always restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd1);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, jump redirect with timed flush, halt.
// Optional jump statistics output taken_count enabled by PC_SEQ_BRANCH_STATS_EN.
module pc_sequencer #(
  parameter int                  PC_WIDTH     = cpu_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = PC_WIDTH'(cpu_pkg::DEFAULT_RESET_PC),
  parameter int                  PC_STEP      = cpu_pkg::PC_STEP,
  parameter int                  FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                jump_take,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                stall,
  input  logic                halt_req,
  input  logic                fetch_ready,
  output logic                fetch_valid,
  output logic [PC_WIDTH-1:0] fetch_pc,
  output logic                flush,
  output logic                halted
`ifdef PC_SEQ_BRANCH_STATS_EN
  ,
  output logic [15:0]         taken_count
`endif
);

  import cpu_pkg::*;

  localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(1);
  localparam logic [3:0]          FLUSH_LOAD = 4'(FLUSH_CYCLES);

  pc_state_t           state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt;
  logic                timer_load, timer_dec, timer_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // RUN priority: halt, then jump (overrides stall and a pending handshake), then stall, then accept.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (halt_req) begin
          state_nxt = HALTED;
        end else if (jump_take) begin
          pc_nxt     = jump_target & ALIGN_MASK;
          state_nxt  = FLUSH;
          timer_load = 1'b1;
        end else if (!stall && fetch_ready) begin
          pc_nxt = pc + STEP;
        end
      end
      FLUSH: begin
        timer_dec = 1'b1;
        if (timer_done) begin
          state_nxt = RUN;
        end
      end
      HALTED: state_nxt = HALTED;
    endcase
  end

  flush_timer u_flush_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (FLUSH_LOAD),
    .dec        (timer_dec),
    .done       (timer_done)
  );

  assign fetch_valid = (state == RUN) && !stall;
  assign fetch_pc    = pc;
  assign flush       = (state == FLUSH);
  assign halted      = (state == HALTED);

`ifdef PC_SEQ_BRANCH_STATS_EN
  logic [15:0] taken_q;
  logic        jump_honored;

  assign jump_honored = (state == RUN) && !halt_req && jump_take;

  // Counts only jumps that actually redirect; saturates rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_q <= 16'h0000;
    end else if (jump_honored && (taken_q != 16'hFFFF)) begin
      taken_q <= taken_q + 16'h0001;
    end
  end

  assign taken_count = taken_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: accepted fetch addresses are scoreboarded per DUT.
// Statistics checks are compiled only when PC_SEQ_BRANCH_STATS_EN is defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jt1, st1, hr1, fr1;
  logic [15:0] tgt1;
  logic        fv1, flush1, halted1;
  logic [15:0] pc1;

  logic        rst2 = 1'b1;
  logic        jt2, st2, hr2, fr2;
  logic [15:0] tgt2;
  logic        fv2, flush2, halted2;
  logic [15:0] pc2;

`ifdef PC_SEQ_BRANCH_STATS_EN
  logic [15:0] tc1, tc2;
`endif

  int checks = 0;
  int errors = 0;
  logic [15:0] q1[$];
  logic [15:0] q2[$];

  always #5 clk = ~clk;

  pc_sequencer dut1 (
    .clk(clk), .rst(rst), .jump_take(jt1), .jump_target(tgt1), .stall(st1),
    .halt_req(hr1), .fetch_ready(fr1), .fetch_valid(fv1), .fetch_pc(pc1),
    .flush(flush1), .halted(halted1)
`ifdef PC_SEQ_BRANCH_STATS_EN
    , .taken_count(tc1)
`endif
  );

  pc_sequencer #(.RESET_PC(16'hFFFC)) dut2 (
    .clk(clk), .rst(rst2), .jump_take(jt2), .jump_target(tgt2), .stall(st2),
    .halt_req(hr2), .fetch_ready(fr2), .fetch_valid(fv2), .fetch_pc(pc2),
    .flush(flush2), .halted(halted2)
`ifdef PC_SEQ_BRANCH_STATS_EN
    , .taken_count(tc2)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic jt, input logic [15:0] tgt, input logic st,
                               input logic hr, input logic fr);
    jt1  = jt;
    tgt1 = tgt;
    st1  = st;
    hr1  = hr;
    fr1  = fr;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Every accepted fetch must match the next expected address.
  always @(negedge clk) begin
    if (!rst && fv1 && fr1) begin
      checkOutput("q1_nonempty", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) checkOutput("fetch_pc1", 32'(pc1), 32'(q1.pop_front()));
    end
    if (!rst2 && fv2 && fr2) begin
      checkOutput("q2_nonempty", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) checkOutput("fetch_pc2", 32'(pc2), 32'(q2.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    jt2 = 1'b0; tgt2 = 16'h0000; st2 = 1'b0; hr2 = 1'b0; fr2 = 1'b1;
    #12;
    checkOutput("rst_fv", 32'(fv1), 32'd0);
    checkOutput("rst_flush", 32'(flush1), 32'd0);
    checkOutput("rst_halted", 32'(halted1), 32'd0);
    checkOutput("rst_pc", 32'(pc1), 32'h0000);
    checkOutput("rst_pc2", 32'(pc2), 32'hFFFC);

    q1.push_back(16'h0000); q1.push_back(16'h0002); q1.push_back(16'h0004);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); checkOutput("boot_no_fetch", 32'(fv1), 32'd0);
    cycle(); @(negedge clk); checkOutput("run_fv", 32'(fv1), 32'd1);
    cycle(); @(negedge clk);
    cycle(); applyStimulus(1'b1, 16'h0123, 1'b0, 1'b0, 1'b1); q1.push_back(16'h0122);
    @(negedge clk);
    // second jump lands in the first flush cycle and must be ignored
    cycle(); applyStimulus(1'b1, 16'h0800, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("flush_c1", 32'(flush1), 32'd1);
    checkOutput("flush_c1_fv", 32'(fv1), 32'd0);
    cycle(); applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("flush_c2", 32'(flush1), 32'd1);
    checkOutput("flush_c2_fv", 32'(fv1), 32'd0);
    q1.push_back(16'h0124);
    cycle(); @(negedge clk);
    checkOutput("flush_end", 32'(flush1), 32'd0);
    checkOutput("resume_pc", 32'(pc1), 32'h0122);

    cycle(); applyStimulus(1'b1, 16'h0011, 1'b0, 1'b0, 1'b1); q1.push_back(16'h0010);
    @(negedge clk);
    cycle(); applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk); checkOutput("flush_b", 32'(flush1), 32'd1);
    cycle(); @(negedge clk); checkOutput("flush_b2", 32'(flush1), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(); applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("ready_low_fv", 32'(fv1), 32'd1);
      checkOutput("ready_low_pc", 32'(pc1), 32'h0010);
    end
    q1.push_back(16'h0012);
    cycle(); applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cycle(); applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("stall_fv", 32'(fv1), 32'd0);
      checkOutput("stall_pc", 32'(pc1), 32'h0012);
    end
    cycle(); applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    // jump while stalled still redirects
    cycle(); applyStimulus(1'b1, 16'h0040, 1'b1, 1'b0, 1'b1);
    @(negedge clk); checkOutput("stall_jump_fv", 32'(fv1), 32'd0);
    cycle(); applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("jump_over_stall_flush", 32'(flush1), 32'd1);
    checkOutput("jump_over_stall_pc", 32'(pc1), 32'h0040);
`ifdef PC_SEQ_BRANCH_STATS_EN
    checkOutput("taken_count3", 32'(tc1), 32'd3);
`endif
    cycle(); #2; rst = 1'b1; #1;
    checkOutput("rst_mid_flush", 32'(flush1), 32'd0);
    checkOutput("rst_mid_fv", 32'(fv1), 32'd0);
    checkOutput("rst_mid_pc", 32'(pc1), 32'h0000);
    q1.delete();
    q1.push_back(16'h0000);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); checkOutput("reboot_no_fetch", 32'(fv1), 32'd0);
    cycle(); @(negedge clk);
    cycle(); applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("q1_drained", 32'(q1.size()), 32'd0);
    checkOutput("reboot_pc", 32'(pc1), 32'h0002);

`ifdef PC_SEQ_BRANCH_STATS_EN
    force dut1.taken_q = 16'hFFFE;
    cycle();
    release dut1.taken_q;
    @(negedge clk); checkOutput("tc_preload", 32'(tc1), 32'h0000FFFE);
    cycle(); applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    cycle(); applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk); checkOutput("tc_full", 32'(tc1), 32'h0000FFFF);
    cycle(); cycle();
    applyStimulus(1'b1, 16'h0200, 1'b0, 1'b0, 1'b0);
    cycle(); applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk); checkOutput("tc_saturate", 32'(tc1), 32'h0000FFFF);
`endif

    q2.push_back(16'hFFFC); q2.push_back(16'hFFFE);
    q2.push_back(16'h0000); q2.push_back(16'h0002);
    @(posedge clk); #1; rst2 = 1'b0;
    @(negedge clk); checkOutput("boot2_no_fetch", 32'(fv2), 32'd0);
    cycle(); @(negedge clk);
    cycle(); @(negedge clk);
    cycle(); @(negedge clk); checkOutput("wrap_pc", 32'(pc2), 32'h0000);
    cycle(); hr2 = 1'b1; jt2 = 1'b1; tgt2 = 16'h0200;
    @(negedge clk);
    cycle(); hr2 = 1'b0;
    @(negedge clk);
    checkOutput("halted", 32'(halted2), 32'd1);
    checkOutput("halt_fv", 32'(fv2), 32'd0);
    checkOutput("halt_flush", 32'(flush2), 32'd0);
    checkOutput("halt_pc", 32'(pc2), 32'h0002);
    for (int i = 0; i < 2; i++) begin
      cycle(); @(negedge clk);
      checkOutput("halt_frozen_pc", 32'(pc2), 32'h0002);
      checkOutput("halt_hold", 32'(halted2), 32'd1);
    end
    cycle(); #2; rst2 = 1'b1; #1;
    checkOutput("rst2_pc", 32'(pc2), 32'hFFFC);
    checkOutput("rst2_halted", 32'(halted2), 32'd0);
    checkOutput("rst2_fv", 32'(fv2), 32'd0);
    checkOutput("q2_drained", 32'(q2.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer for the 16-bit CPU. It consumes the single-bit jump decision and jump target from the jump control stage, and drives instruction fetch through a valid/ready handshake. On a taken jump it redirects the PC and issues a timed flush that squashes wrong-path instructions. It sits between the execute-stage jump decision and the instruction memory port.

Parameters:
PC_WIDTH, 16, width of PC and jump target
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 2, sequential PC increment (byte-addressed 16-bit instructions)
FLUSH_CYCLES, 2, cycles flush is held after a taken jump (legal range 1..15)

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  reset, asynchronous, active-high
jump_take  in  1  jump decision from jump control stage
jump_target  in  PC_WIDTH  target address, valid when jump_take=1
stall  in  1  pipeline stall request, holds fetch
halt_req  in  1  halt instruction resolved in execute
fetch_ready  in  1  instruction memory accepts request
fetch_valid  out  1  fetch request valid
fetch_pc  out  PC_WIDTH  address of current fetch request
flush  out  1  squash younger pipeline stages
halted  out  1  sequencer in HALTED state

Behaviour:
- Reset (asynchronous, any state): state=BOOT, pc=RESET_PC, fetch_valid=0, flush=0, halted=0, flush counter=0.
- All outputs are registered or decoded from state; no combinational path from jump_take to fetch_valid.
- States: BOOT, RUN, FLUSH, HALTED.
- BOOT: lasts one cycle, then RUN. No fetch is issued.
- RUN: fetch_valid = !stall; fetch_pc = pc.
- RUN event priority, evaluated per cycle: halt_req > jump_take > stall > accept.
  - halt_req=1: go to HALTED. pc holds. fetch_valid=0 from the next cycle. halted=1.
  - jump_take=1: pc <= {jump_target[15:1],1'b0} (bit0 forced to 0). Go to FLUSH. flush=1 starting the next cycle. counter=FLUSH_CYCLES. A jump overrides stall and a pending handshake.
  - stall=1: pc holds. fetch_valid=0.
  - accept (fetch_valid && fetch_ready): pc <= pc+PC_STEP, modulo 2^PC_WIDTH, so 16'hFFFE -> 16'h0000.
  - fetch_valid && !fetch_ready: pc and fetch_valid stay stable until accepted.
- FLUSH: flush=1 and fetch_valid=0. The counter decrements every cycle; when it reaches 1, the next state is RUN and flush drops on entry to RUN. jump_take and halt_req are ignored in FLUSH because they come from squashed instructions. stall does not extend FLUSH.
- Flush duration is exactly FLUSH_CYCLES cycles. The first new-target fetch is presented FLUSH_CYCLES+1 cycles after the jump_take cycle.
- HALTED: fetch_valid=0, flush=0, halted=1, pc frozen. Only rst exits this state.
- Reset mid-FLUSH or mid-handshake: all state is discarded and the sequencer restarts at BOOT.
- Simultaneous jump_take and accept in the same cycle: the jump wins and the accepted fetch is the last wrong-path fetch, squashed by flush.

Optional Feature:
Macro: PC_SEQ_BRANCH_STATS_EN.
- Defined: adds output port taken_count[15:0]. It resets to 0 and increments once per jump honored in RUN (not for jumps ignored in FLUSH). It saturates at 16'hFFFF.
- Undefined: the port and counter are absent, and core behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_WIDTH and PC_STEP constants;
  - the state enum, pc_state_t {BOOT, RUN, FLUSH, HALTED};
  - the default RESET_PC.
- Sub-module flush_timer: a 4-bit load/decrement counter with a done output. It is loaded with FLUSH_CYCLES and is instantiated once.

Test Plan:
- Reset release, fetch_ready=1 tied, no events -> BOOT one cycle; fetch_pc sequence 0000, 0002, 0004, 0006 on consecutive cycles.
- At fetch_pc=0004, pulse jump_take=1 with jump_target=0x0123 -> flush=1 for 2 cycles, fetch_valid=0; next fetch_pc=0x0122 on cycle 3 after the jump.
- Jump during FLUSH: second jump_take with target 0x0800 on flush cycle 1 -> ignored; fetch resumes at 0x0122.
- fetch_ready=0 for 3 cycles at pc=0x0010 -> fetch_valid=1 and fetch_pc=0x0010 stable; advances to 0x0012 one cycle after fetch_ready=1. stall=1 -> fetch_valid=0, pc holds.
- Wrap and halt: RESET_PC=0xFFFC, accepts -> FFFC, FFFE, 0000. Then assert halt_req with jump_take=1 -> HALTED, halted=1, pc frozen. Assert rst asynchronously mid-cycle -> outputs at reset values immediately.
- With PC_SEQ_BRANCH_STATS_EN defined: 3 honored jumps plus 1 ignored jump in FLUSH -> taken_count=3; preload near saturation -> holds 0xFFFF.
